// File: rtl/regf_scoreboard_mp.sv
// ---------------------------------------------------------------------------
// regf_scoreboard_mp
//
// Register-file scoreboard for the SXP pipeline. It keeps one small
// pending-write counter per register, so several in-flight writes to the same
// register can be tracked. From those counters it derives stall_regf for the
// decode/regf stages. A drain FSM quiesces the pipeline for context switches.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   reset_i          synchronous active-high reset
//   halt_i           freeze counters (no issue, no retire)
//   stall_i          pipeline stall, suppresses destination issue
//   dest_en_i        issuing instruction has a destination register
//   dest_addr_i      destination address of the issuing instruction
//   wec_i            per-port write-back request (NWB ports)
//   addrc_i          per-port write-back address, port i = [i*AW +: AW]
//   src_en_i         per-port source operand valid (NSRC ports)
//   src_addr_i       per-port source address, port j = [j*AW +: AW]
//   flush_pipeline_i clear all pending state (the FSM state is kept)
//   drain_req_i      level request to quiesce
//   stall_regf_o     combinational stall toward regf and the earlier stages
//   safe_switch_o    every registered counter is zero
//   drain_done_o     drain complete, held while drain_req_i stays high
//   err_underflow_o  sticky: a retire hit a register with no pending write
// ---------------------------------------------------------------------------
module regf_scoreboard_mp #(
    parameter int AW       = 5,
    parameter int NREG     = 32,
    parameter int CW       = 2,
    parameter int NWB      = 2,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              halt_i,
    input  logic              stall_i,
    input  logic              dest_en_i,
    input  logic [AW-1:0]     dest_addr_i,
    input  logic [NWB-1:0]    wec_i,
    input  logic [NWB*AW-1:0] addrc_i,
    input  logic [NSRC-1:0]   src_en_i,
    input  logic [NSRC*AW-1:0] src_addr_i,
    input  logic              flush_pipeline_i,
    input  logic              drain_req_i,
    output logic              stall_regf_o,
    output logic              safe_switch_o,
    output logic              drain_done_o,
    output logic              err_underflow_o
);

    localparam int MAX_CNT = 2**CW - 1;
    localparam int DW      = $clog2(NWB + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q [NREG];
    logic [CW-1:0]     cnt_d [NREG];
    logic              err_q, err_d;

    logic [DW-1:0]     dec [NREG];   // retires aimed at each register this cycle
    logic [NREG-1:0]   live;         // still pending after this cycle's retires
    logic [NREG-1:0]   full;         // no room for another in-flight write
    logic [NREG-1:0]   inc;
    logic              src_hazard;
    logic              dest_full;
    logic              issue_blk;
    logic              all_zero;

    // Per-register retire count and the bypassed view of each counter.
    // Out-of-range addresses never match any r, so they are ignored for free.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r]  = '0;
            live[r] = 1'b0;
            full[r] = 1'b0;
            if (!(ZERO_REG != 0 && r == 0)) begin
                for (int i = 0; i < NWB; i++) begin
                    if (wec_i[i] && addrc_i[i*AW +: AW] == AW'(r)) begin
                        dec[r] = dec[r] + DW'(1);
                    end
                end
                // A same-cycle retire only clears the hazard when it covers
                // every pending write, hence the comparison against dec.
                live[r] = int'(cnt_q[r]) > int'(dec[r]);
                full[r] = (int'(cnt_q[r]) - int'(dec[r])) == MAX_CNT;
            end
        end
    end

    always_comb begin
        src_hazard = 1'b0;
        dest_full  = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            for (int j = 0; j < NSRC; j++) begin
                if (src_en_i[j] && src_addr_i[j*AW +: AW] == AW'(r) && live[r]) begin
                    src_hazard = 1'b1;
                end
            end
            if (dest_en_i && dest_addr_i == AW'(r) && full[r]) begin
                dest_full = 1'b1;
            end
        end
        issue_blk = dest_full | (dest_en_i & (state_q != ST_IDLE)) | src_hazard;
    end

    always_comb begin
        inc = '0;
        for (int r = 0; r < NREG; r++) begin
            if (!(ZERO_REG != 0 && r == 0)) begin
                inc[r] = dest_en_i & ~stall_i & ~issue_blk & (dest_addr_i == AW'(r));
            end
        end
    end

    // Counter next state; a retire beyond the pending count clamps to zero
    // and raises the sticky error.
    always_comb begin
        int nxt;
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            nxt = int'(cnt_q[r]) + int'(inc[r]) - int'(dec[r]);
            if (nxt < 0) begin
                nxt   = 0;
                err_d = 1'b1;
            end
            cnt_d[r] = CW'(nxt);
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (cnt_q[r] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    // Drain FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (drain_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req_i)  state_d = ST_IDLE;
                else if (all_zero) state_d = ST_DONE;
            end
            ST_DONE:  if (!drain_req_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the counter array is real state the stall logic reads,
            // so every entry is reset, unlike a data RAM.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
            if (flush_pipeline_i) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt_q[r] <= '0;
                end
                err_q <= 1'b0;
            end else if (!halt_i) begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end
    end

    assign stall_regf_o    = issue_blk;
    assign safe_switch_o   = all_zero;
    assign drain_done_o    = (state_q == ST_DONE);
    assign err_underflow_o = err_q;

endmodule

// File: tb/tb_regf_scoreboard_mp.sv
// ---------------------------------------------------------------------------
// tb_regf_scoreboard_mp
//
// Directed bench for regf_scoreboard_mp with default parameters. A
// behavioural model (integer pending counts per register plus a drain phase)
// predicts every output on each falling clock edge; directed literal checks
// pin both the DUT and the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_regf_scoreboard_mp;

    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int NWB  = 2;
    localparam int NSRC = 2;
    localparam int MAXP = 3;

    logic               clk_i;
    logic               reset_i;
    logic               halt_i;
    logic               stall_i;
    logic               dest_en_i;
    logic [AW-1:0]      dest_addr_i;
    logic [NWB-1:0]     wec_i;
    logic [NWB*AW-1:0]  addrc_i;
    logic [NSRC-1:0]    src_en_i;
    logic [NSRC*AW-1:0] src_addr_i;
    logic               flush_pipeline_i;
    logic               drain_req_i;
    logic               stall_regf_o;
    logic               safe_switch_o;
    logic               drain_done_o;
    logic               err_underflow_o;

    regf_scoreboard_mp dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .halt_i           (halt_i),
        .stall_i          (stall_i),
        .dest_en_i        (dest_en_i),
        .dest_addr_i      (dest_addr_i),
        .wec_i            (wec_i),
        .addrc_i          (addrc_i),
        .src_en_i         (src_en_i),
        .src_addr_i       (src_addr_i),
        .flush_pipeline_i (flush_pipeline_i),
        .drain_req_i      (drain_req_i),
        .stall_regf_o     (stall_regf_o),
        .safe_switch_o    (safe_switch_o),
        .drain_done_o     (drain_done_o),
        .err_underflow_o  (err_underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int pend [NREG];     // outstanding writes per register
    int phase;           // 0 idle, 1 draining, 2 drained
    bit err_m;
    bit model_ok = 1'b0;

    always @(negedge clk_i) begin
        int  ret [NREG];
        bit  hz, full, blk, safe, issue;
        int  v;
        if (reset_i) begin
            foreach (pend[r]) pend[r] = 0;
            phase    = 0;
            err_m    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            foreach (ret[r]) ret[r] = 0;
            for (int i = 0; i < NWB; i++)
                if (wec_i[i]) ret[addrc_i[i*AW +: AW]]++;
            hz = 1'b0;
            for (int j = 0; j < NSRC; j++)
                if (src_en_i[j] && pend[src_addr_i[j*AW +: AW]] - ret[src_addr_i[j*AW +: AW]] > 0)
                    hz = 1'b1;
            full  = dest_en_i && (pend[dest_addr_i] - ret[dest_addr_i] == MAXP);
            blk   = full || (dest_en_i && phase != 0) || hz;
            safe  = 1'b1;
            foreach (pend[r]) if (pend[r] != 0) safe = 1'b0;

            check("stall_regf",    32'(stall_regf_o),    32'(blk));
            check("safe_switch",   32'(safe_switch_o),   32'(safe));
            check("drain_done",    32'(drain_done_o),    32'(phase == 2));
            check("err_underflow", 32'(err_underflow_o), 32'(err_m));

            case (phase)
                0: if (drain_req_i) phase = 1;
                1: if (!drain_req_i) phase = 0; else if (safe) phase = 2;
                default: if (!drain_req_i) phase = 0;
            endcase

            if (flush_pipeline_i) begin
                foreach (pend[r]) pend[r] = 0;
                err_m = 1'b0;
            end else if (!halt_i) begin
                issue = dest_en_i && !stall_i && !blk;
                foreach (pend[r]) begin
                    v = pend[r] - ret[r] + ((issue && dest_addr_i == AW'(r)) ? 1 : 0);
                    if (v < 0) begin
                        v     = 0;
                        err_m = 1'b1;
                    end
                    pend[r] = v;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        halt_i           = 1'b0;
        stall_i          = 1'b0;
        dest_en_i        = 1'b0;
        dest_addr_i      = '0;
        wec_i            = '0;
        addrc_i          = '0;
        src_en_i         = '0;
        src_addr_i       = '0;
        flush_pipeline_i = 1'b0;
    endtask

    task automatic dest(input int a);
        dest_en_i   = 1'b1;
        dest_addr_i = AW'(a);
    endtask

    task automatic wb(input int port, input int a);
        wec_i[port]              = 1'b1;
        addrc_i[port*AW +: AW]   = AW'(a);
    endtask

    task automatic src(input int port, input int a);
        src_en_i[port]             = 1'b1;
        src_addr_i[port*AW +: AW]  = AW'(a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        clr();
        drain_req_i = 1'b0;
        reset_i     = 1'b1;
        repeat (2) cyc();
        reset_i = 1'b0;
        #1;
        check("rst_safe",  32'(safe_switch_o),   32'd1);
        check("rst_stall", 32'(stall_regf_o),    32'd0);
        check("rst_done",  32'(drain_done_o),    32'd0);
        check("rst_err",   32'(err_underflow_o), 32'd0);

        // 1: issue r5, source hazard, bypass by the last retire
        dest(5); cyc(); clr();
        check("t1_cnt5", pend[5], 1);
        check("t1_safe", 32'(safe_switch_o), 32'd0);
        src(0, 5); #1;
        check("t1_hazard", 32'(stall_regf_o), 32'd1);
        wb(0, 5); #1;
        check("t1_bypass", 32'(stall_regf_o), 32'd0);
        cyc(); clr();
        check("t1_cnt5_ret", pend[5], 0);

        // 2: counter saturation on r7
        repeat (3) begin dest(7); cyc(); end
        check("t2_cnt7", pend[7], 3);
        #1;
        check("t2_full_stall", 32'(stall_regf_o), 32'd1);
        cyc();
        check("t2_cnt7_held", pend[7], 3);
        wb(0, 7); #1;
        check("t2_issue_with_retire", 32'(stall_regf_o), 32'd0);
        cyc(); clr();
        check("t2_cnt7_after", pend[7], 3);
        wb(0, 7); wb(1, 7); cyc(); clr();
        wb(1, 7); cyc(); clr();
        check("t2_cnt7_drained", pend[7], 0);

        // 3: dual retire on r9, then underflow
        dest(9); cyc(); dest(9); cyc(); clr();
        wb(0, 9); wb(1, 9); cyc(); clr();
        check("t3_cnt9", pend[9], 0);
        check("t3_no_err", 32'(err_underflow_o), 32'd0);
        wb(0, 9); cyc(); clr();
        check("t3_err_set", 32'(err_underflow_o), 32'd1);
        cyc();
        check("t3_err_sticky", 32'(err_underflow_o), 32'd1);
        flush_pipeline_i = 1'b1; cyc(); clr();
        check("t3_err_flushed", 32'(err_underflow_o), 32'd0);

        // 4: halt freezes issue and retire
        dest(4); cyc(); clr();
        halt_i = 1'b1; dest(3); wb(0, 4); cyc();
        check("t4_cnt4_halt", pend[4], 1);
        check("t4_cnt3_halt", pend[3], 0);
        check("t4_safe_halt", 32'(safe_switch_o), 32'd0);
        halt_i = 1'b0; cyc(); clr();
        check("t4_cnt3_rel", pend[3], 1);
        check("t4_cnt4_rel", pend[4], 0);
        wb(1, 3); cyc(); clr();
        check("t4_safe", 32'(safe_switch_o), 32'd1);

        // 5: drain with pending r2, r6
        dest(2); cyc(); dest(6); cyc(); clr();
        drain_req_i = 1'b1; cyc();
        dest(10); #1;
        check("t5_drain_stall", 32'(stall_regf_o), 32'd1);
        cyc(); clr();
        check("t5_cnt10", pend[10], 0);
        wb(0, 2); wb(1, 6); cyc(); clr();
        check("t5_not_done_yet", 32'(drain_done_o), 32'd0);
        cyc();
        check("t5_done", 32'(drain_done_o), 32'd1);
        drain_req_i = 1'b0; cyc();
        check("t5_idle", 32'(drain_done_o), 32'd0);
        dest(11); #1;
        check("t5_issue_resumes", 32'(stall_regf_o), 32'd0);
        cyc(); clr();
        check("t5_cnt11", pend[11], 1);
        wb(0, 11); cyc(); clr();

        // 6: flush clears pending r1..r4
        for (int r = 1; r <= 4; r++) begin dest(r); cyc(); end
        clr();
        check("t6_pending", 32'(safe_switch_o), 32'd0);
        flush_pipeline_i = 1'b1; cyc(); clr();
        check("t6_flush_safe", 32'(safe_switch_o), 32'd1);

        // flush during DRAIN: DONE on the following edge
        dest(1); cyc(); clr();
        drain_req_i = 1'b1; cyc();
        flush_pipeline_i = 1'b1; cyc(); clr();
        check("t6_flush_drain_wait", 32'(drain_done_o), 32'd0);
        cyc();
        check("t6_flush_drain_done", 32'(drain_done_o), 32'd1);
        drain_req_i = 1'b0; cyc();

        // reset in the middle of DRAIN
        dest(1); cyc(); clr();
        drain_req_i = 1'b1; cyc(); cyc();
        dest(3); #1;
        check("t6_drain_blocks", 32'(stall_regf_o), 32'd1);
        clr();
        reset_i = 1'b1; drain_req_i = 1'b0; cyc();
        reset_i = 1'b0; #1;
        check("t6_rst_done", 32'(drain_done_o),  32'd0);
        check("t6_rst_safe", 32'(safe_switch_o), 32'd1);
        dest(3); #1;
        check("t6_rst_idle", 32'(stall_regf_o), 32'd0);
        cyc(); clr();
        check("t6_cnt3", pend[3], 1);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
